// File: rtl/aes_usb_pkg.sv
// Types and constants shared by the AES/USB datapath blocks.
package aes_usb_pkg;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BLOCK_BITS  = 128;

    typedef logic [BLOCK_BITS-1:0] aes_block_t;

    typedef enum logic {RD_FILL, RD_VALID} rd_state_t;

endpackage

// File: rtl/fifo_block_reader.sv
// Pops bytes from a show-ahead FIFO and packs them into AES blocks, MSB lane first.
module fifo_block_reader
    import aes_usb_pkg::*;
#(
    parameter int unsigned NUMBITS    = 8,
    parameter int unsigned BLOCKBYTES = BLOCK_BYTES,
    parameter int unsigned CNTBITS    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_empty,
    input  logic [NUMBITS-1:0]            fifo_r_data,
    output logic                          fifo_r_en,
    input  logic                          flush,
    output logic [NUMBITS*BLOCKBYTES-1:0] block_data,
    output logic [CNTBITS-1:0]            block_len,
    output logic                          block_valid,
    input  logic                          block_ready
);

    localparam logic [CNTBITS-1:0] LAST_IDX = CNTBITS'(BLOCKBYTES - 1);

    rd_state_t                     state_q, state_d;
    logic [CNTBITS-1:0]            count_q;
    logic [NUMBITS*BLOCKBYTES-1:0] shift_q;
    logic                          pop;
    logic                          close;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        close   = 1'b0;
        unique case (state_q)
            RD_FILL: begin
                pop   = !fifo_empty;
                // A flush on an empty FIFO only closes a block that already holds data.
                close = (pop && (count_q == LAST_IDX || flush)) ||
                        (flush && fifo_empty && count_q != '0);
                if (close) state_d = RD_VALID;
            end
            RD_VALID: begin
                if (block_ready) state_d = RD_FILL;
            end
            default: state_d = RD_FILL;
        endcase
        fifo_r_en = pop && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RD_FILL;
            count_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RD_VALID && block_ready) begin
                count_q <= '0;
                shift_q <= '0;
            end else if (pop) begin
                count_q <= count_q + CNTBITS'(1);
                for (int i = 0; i < int'(BLOCKBYTES); i++) begin
                    if (count_q == CNTBITS'(i))
                        shift_q[(int'(BLOCKBYTES) - 1 - i)*int'(NUMBITS) +: NUMBITS] <= fifo_r_data;
                end
            end
        end
    end

    // count_q freezes at the final length while the block waits in RD_VALID.
    assign block_valid = (state_q == RD_VALID);
    assign block_len   = block_valid ? count_q : '0;
    assign block_data  = shift_q;

endmodule
